uart_tx_8n1: RTL
================

// Module: uart_tx_8n1
// PURPOSE
//   UART transmitter. Serialises bytes into 8N1 frames on txd: start 0, 8 data bits LSB first, stop 1.
//   Feeds the serial capture/logging stage, which samples txd once per bit period and writes the bits to file.
//   Byte input uses a valid/ready handshake. A one-deep holding register allows back-to-back frames with no idle gap.
// PARAMETERS
//   CLKS_PER_BIT  4  clock cycles per serial bit; legal range >= 2
//   DATA_BITS     8  data bits per frame; legal range 5..8
// PORTS
//   clk       in   1          system clock; all logic on rising edge
//   rst_n     in   1          synchronous reset, active-low
//   in_data   in   DATA_BITS  byte to transmit
//   in_valid  in   1          in_data is valid
//   in_ready  out  1          block can accept a byte this cycle
//   txd       out  1          serial line; idles high
//   busy      out  1          a frame is on the line (START..STOP)
//   tx_done   out  1          1-cycle pulse in the last cycle of each stop bit
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): next-cycle values txd=1, busy=0, tx_done=0, in_ready=1.
//     The holding register is emptied, the FSM goes to IDLE and the bit/cycle counters clear.
//     Reset mid-frame abandons the frame; txd goes high after the next edge and no tx_done pulse is produced.
//   Handshake: a transfer occurs on an edge where in_valid & in_ready are both high. in_ready = !hold_full.
//   FSM states are IDLE, START, DATA and STOP. A baud counter counts 0..CLKS_PER_BIT-1. A bit index counts 0..DATA_BITS-1.
//   IDLE: txd=1, busy=0.
//     On an accept, the byte loads straight into the shift register (the holding register is bypassed) and the FSM goes to START.
//     txd goes low in the cycle after the accept edge (latency 1).
//   START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
//   DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
//     After the cycles for bit DATA_BITS-1 the FSM goes to STOP.
//   STOP: txd=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle only.
//     End of STOP with hold_full: load hold into the shifter, clear hold_full, go to START. No idle cycle between frames.
//     End of STOP with hold empty: go to IDLE.
//   Accepts while busy go into the holding register. in_ready then drops in the cycle after the accept.
//   An accept in the final STOP cycle while hold is empty: the byte goes to hold, then to the shifter next cycle.
//     This adds one idle cycle with txd=1 before the next START.
//   Frame length is (DATA_BITS+2)*CLKS_PER_BIT cycles. For the defaults that is 40 cycles.
//   in_data is sampled only on the accept edge. Later changes to in_data do not affect the frame.
//   The counters never wrap mid-bit. The baud counter resets to 0 on every state or bit change.
//   in_valid without in_ready is ignored. The source must hold in_data and in_valid until it sees in_ready.
//   busy=1 in every cycle where the state is START, DATA or STOP.
// TESTING
//   1 Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> txd=1, busy=0, in_ready=1, no frame starts.
//   2 Single byte 0x55 accepted while idle, defaults.
//     -> txd is 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles. First low one cycle after accept.
//     -> tx_done pulses at cycle 40, then IDLE.
//   3 Back-to-back 0x55 then 0xA3, both offered continuously.
//     -> second byte accepted during frame 1 and in_ready stays 0 until frame 2 starts.
//     -> frame 2 is 0,1,1,0,0,0,1,0,1,1 and starts the cycle after frame 1's tx_done, with no high gap.
//   4 Backpressure: hold full, offer 0xFF with in_valid=1 -> not accepted until in_ready rises.
//     -> exactly 3 frames are sent for 3 offered bytes, with none lost or duplicated.
//   5 Reset mid-frame: rst_n=0 for 1 cycle during DATA bit 3.
//     -> txd=1 and busy=0 next cycle, no tx_done, pending hold byte discarded.
//     -> a new byte 0x0F then produces a clean frame 0,1,1,1,1,0,0,0,0,1.
//   6 CLKS_PER_BIT=2, DATA_BITS=7, byte 0x41 -> 9 bits of 2 cycles each: 0,1,0,0,0,0,0,1,1.
//     -> tx_done at cycle 18.

Source files
------------

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with valid/ready byte input and one-deep holding register
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 accept, baud_last, bit_last;

  assign in_ready = !hold_full_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    accept      = in_valid && !hold_full_q;
    baud_last   = (baud_q == BW'(CLKS_PER_BIT - 1));
    bit_last    = (bit_q == IW'(DATA_BITS - 1));

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
          baud_d      = '0;
        end else if (accept) begin
          shift_d = in_data;
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_last) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepts outside IDLE park in hold; this overrides the STOP-end handling above.
    if (accept && state_q != IDLE) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    txd_d     = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_d == STOP) && (baud_d == BW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
    end
  end
endmodule
